// File: rtl/cdb_pkg.sv
// -----------------------------------------------------------------------------
// cdb_pkg
// Shared types and constants for the common data bus (CDB) arbiter slice.
//   XLEN        : data / PC width.
//   ROB_W_DEF   : default ROB index width.
//   cdb_entry_t : one result travelling towards the CDB.
//   cdb_src_e   : producer identity (ALU or LSB), also the round-robin pointer.
// -----------------------------------------------------------------------------
package cdb_pkg;

  localparam int XLEN      = 32;
  localparam int ROB_W_DEF = 5;

  typedef struct packed {
    logic [XLEN-1:0]      res;
    logic [ROB_W_DEF-1:0] rob_id;
    logic                 jump;
    logic [XLEN-1:0]      pc;
  } cdb_entry_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } cdb_src_e;

  function automatic cdb_src_e other_src(input cdb_src_e s);
    return (s == SRC_ALU) ? SRC_LSB : SRC_ALU;
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// -----------------------------------------------------------------------------
// cdb_fifo
// Per-source result queue feeding the CDB arbiter.
//   clk, rst : clock, asynchronous active-high reset.
//   rdy      : global ready; when low the FIFO is frozen.
//   flush    : drop all entries (takes priority over push/pop).
//   push/din : enqueue din (ignored when full).
//   pop      : dequeue the head (ignored when empty).
//   head     : current oldest entry (valid when !empty).
//   empty    : no entries stored.
//   count    : number of stored entries, 0..DEPTH.
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module cdb_fifo
  import cdb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  cdb_entry_t din,
  output cdb_entry_t head,
  output logic       empty,
  output logic [AW:0] count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  cdb_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign do_push = push && (count < FULL_CNT);
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (rdy) begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        unique case ({do_push, do_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; occupancy is tracked by
  // count/pointers, so stale contents are never observed and the array can map
  // to plain RAM/flops without reset fan-out.
  always_ff @(posedge clk) begin
    if (rdy && !flush && do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Shares one registered common data bus between the ALU and the load/store
// buffer. Each source has a small FIFO; an empty FIFO lets the incoming result
// bypass straight to arbitration. One result per cycle is granted onto the CDB.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset.
//   rdy                 : global ready; low freezes all state and outputs.
//   wrong_commit        : mispredict flush; empties both FIFOs.
//   alu_valid/res/rob_id/jump/jump_pc, alu_ready : ALU producer interface.
//   lsb_valid/res/rob_id, lsb_ready              : LSB producer interface.
//   cdb_valid/res/rob_id/jump/pc/src             : registered CDB broadcast.
//
// Build option:
//   CDB_LSB_PRIORITY_EN : when defined, the LSB always wins a contended cycle
//                         and the round-robin pointer is removed. Otherwise
//                         contended cycles alternate between the sources.
// -----------------------------------------------------------------------------
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ROB_W = ROB_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             wrong_commit,
  input  logic             alu_valid,
  input  logic [XLEN-1:0]  alu_res,
  input  logic [ROB_W-1:0] alu_rob_id,
  input  logic             alu_jump,
  input  logic [XLEN-1:0]  alu_jump_pc,
  output logic             alu_ready,
  input  logic             lsb_valid,
  input  logic [XLEN-1:0]  lsb_res,
  input  logic [ROB_W-1:0] lsb_rob_id,
  output logic             lsb_ready,
  output logic             cdb_valid,
  output logic [XLEN-1:0]  cdb_res,
  output logic [ROB_W-1:0] cdb_rob_id,
  output logic             cdb_jump,
  output logic [XLEN-1:0]  cdb_pc,
  output logic             cdb_src
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // The entry struct carries a fixed-width tag; a mismatched ROB_W is a
  // configuration error caught at elaboration.
  if (ROB_W != ROB_W_DEF) begin : g_rob_w_check
    $error("cdb_arbiter: ROB_W must equal cdb_pkg::ROB_W_DEF");
  end

  cdb_entry_t  alu_in, lsb_in;
  cdb_entry_t  alu_head, lsb_head;
  cdb_entry_t  alu_cand, lsb_cand, win;
  logic        alu_empty, lsb_empty;
  logic [AW:0] alu_count, lsb_count;
  logic        alu_push_ok, lsb_push_ok;
  logic        alu_cand_v, lsb_cand_v;
  logic        grant_alu, grant_lsb;
  logic        contended;
  cdb_src_e    win_src;

  assign alu_in = {alu_res, alu_rob_id, alu_jump, alu_jump_pc};
  assign lsb_in = {lsb_res, lsb_rob_id, 1'b0, {XLEN{1'b0}}};

  // Readiness comes from the registered count only, so a pop from a full FIFO
  // re-opens the producer one cycle later.
  assign alu_ready = (alu_count < FULL_CNT);
  assign lsb_ready = (lsb_count < FULL_CNT);

  assign alu_push_ok = alu_valid && alu_ready;
  assign lsb_push_ok = lsb_valid && lsb_ready;

  // Empty FIFO: the incoming result competes directly (bypass).
  assign alu_cand_v = !alu_empty || alu_push_ok;
  assign lsb_cand_v = !lsb_empty || lsb_push_ok;
  assign alu_cand   = alu_empty ? alu_in : alu_head;
  assign lsb_cand   = lsb_empty ? lsb_in : lsb_head;
  assign contended  = alu_cand_v && lsb_cand_v;

`ifndef CDB_LSB_PRIORITY_EN
  cdb_src_e rr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= SRC_ALU;
    end else if (rdy) begin
      if (wrong_commit)   rr_ptr <= SRC_ALU;
      else if (contended) rr_ptr <= other_src(rr_ptr);
    end
  end
`endif

  // NOTE: every output of this combinational block gets a default first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    grant_alu = 1'b0;
    grant_lsb = 1'b0;
    if (!wrong_commit) begin
      if (contended) begin
`ifdef CDB_LSB_PRIORITY_EN
        grant_lsb = 1'b1;
`else
        grant_alu = (rr_ptr == SRC_ALU);
        grant_lsb = (rr_ptr == SRC_LSB);
`endif
      end else begin
        grant_alu = alu_cand_v;
        grant_lsb = lsb_cand_v;
      end
    end
  end

  assign win     = grant_lsb ? lsb_cand : alu_cand;
  assign win_src = grant_lsb ? SRC_LSB : SRC_ALU;

  // A bypassed entry that wins goes straight to the CDB and is never stored;
  // a losing one lands in the FIFO and becomes its head.
  cdb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .flush (wrong_commit),
    .push  (alu_push_ok && !(grant_alu && alu_empty)),
    .pop   (grant_alu && !alu_empty),
    .din   (alu_in),
    .head  (alu_head),
    .empty (alu_empty),
    .count (alu_count)
  );

  cdb_fifo #(.DEPTH(DEPTH)) u_lsb_fifo (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .flush (wrong_commit),
    .push  (lsb_push_ok && !(grant_lsb && lsb_empty)),
    .pop   (grant_lsb && !lsb_empty),
    .din   (lsb_in),
    .head  (lsb_head),
    .empty (lsb_empty),
    .count (lsb_count)
  );

  // CDB output register. Payload holds its last value on idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid  <= 1'b0;
      cdb_res    <= '0;
      cdb_rob_id <= '0;
      cdb_jump   <= 1'b0;
      cdb_pc     <= '0;
      cdb_src    <= 1'b0;
    end else if (rdy) begin
      if (wrong_commit) begin
        cdb_valid <= 1'b0;
      end else begin
        cdb_valid <= grant_alu || grant_lsb;
        if (grant_alu || grant_lsb) begin
          cdb_res    <= win.res;
          cdb_rob_id <= win.rob_id;
          cdb_jump   <= win.jump;
          cdb_pc     <= win.pc;
          cdb_src    <= win_src;
        end
      end
    end
  end

`ifndef SYNTHESIS
  // Producers must not present a result while their FIFO is full.
  alu_push_protocol : assert property (@(posedge clk) disable iff (rst)
    (rdy && alu_valid) |-> alu_ready)
    else $error("cdb_arbiter: ALU result presented while alu_ready=0, dropped");

  lsb_push_protocol : assert property (@(posedge clk) disable iff (rst)
    (rdy && lsb_valid) |-> lsb_ready)
    else $error("cdb_arbiter: LSB result presented while lsb_ready=0, dropped");
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
// Self-checking bench for cdb_arbiter. A queue-based reference model tracks the
// results each source still owes the CDB and decides every cycle which one
// must be broadcast; a negedge compare process checks the DUT against it.
// Directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cdb_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        wrong_commit = 1'b0;
  logic        alu_valid = 1'b0;
  logic [31:0] alu_res = '0;
  logic [4:0]  alu_rob_id = '0;
  logic        alu_jump = 1'b0;
  logic [31:0] alu_jump_pc = '0;
  logic        alu_ready;
  logic        lsb_valid = 1'b0;
  logic [31:0] lsb_res = '0;
  logic [4:0]  lsb_rob_id = '0;
  logic        lsb_ready;
  logic        cdb_valid;
  logic [31:0] cdb_res;
  logic [4:0]  cdb_rob_id;
  logic        cdb_jump;
  logic [31:0] cdb_pc;
  logic        cdb_src;

  always #5 clk = ~clk;

  cdb_arbiter #(.DEPTH(DEPTH), .ROB_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .wrong_commit (wrong_commit),
    .alu_valid    (alu_valid),
    .alu_res      (alu_res),
    .alu_rob_id   (alu_rob_id),
    .alu_jump     (alu_jump),
    .alu_jump_pc  (alu_jump_pc),
    .alu_ready    (alu_ready),
    .lsb_valid    (lsb_valid),
    .lsb_res      (lsb_res),
    .lsb_rob_id   (lsb_rob_id),
    .lsb_ready    (lsb_ready),
    .cdb_valid    (cdb_valid),
    .cdb_res      (cdb_res),
    .cdb_rob_id   (cdb_rob_id),
    .cdb_jump     (cdb_jump),
    .cdb_pc       (cdb_pc),
    .cdb_src      (cdb_src)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] res;
    logic [4:0]  id;
    logic        jump;
    logic [31:0] pc;
  } ent_t;

  ent_t        aq[$];
  ent_t        lq[$];
  logic        m_ptr   = 1'b0;   // 0 = ALU preferred
  logic        m_valid = 1'b0;
  logic [31:0] m_res   = '0;
  logic [4:0]  m_id    = '0;
  logic        m_jump  = 1'b0;
  logic [31:0] m_pc    = '0;
  logic        m_src   = 1'b0;

  function automatic logic pick_lsb(input int na, input int nl, input logic ptr);
    if (nl == 0) return 1'b0;
    if (na == 0) return 1'b1;
`ifdef CDB_LSB_PRIORITY_EN
    return 1'b1;
`else
    return ptr;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aq.delete();
      lq.delete();
      m_ptr <= 1'b0; m_valid <= 1'b0; m_res <= '0; m_id <= '0;
      m_jump <= 1'b0; m_pc <= '0; m_src <= 1'b0;
    end else if (rdy) begin
      if (wrong_commit) begin
        aq.delete();
        lq.delete();
        m_valid <= 1'b0;
        m_ptr   <= 1'b0;
      end else begin
        if (alu_valid && aq.size() < DEPTH)
          aq.push_back('{res: alu_res, id: alu_rob_id, jump: alu_jump, pc: alu_jump_pc});
        if (lsb_valid && lq.size() < DEPTH)
          lq.push_back('{res: lsb_res, id: lsb_rob_id, jump: 1'b0, pc: 32'h0});
        m_valid <= (aq.size() != 0) || (lq.size() != 0);
        if (aq.size() != 0 && lq.size() != 0) m_ptr <= !m_ptr;
        if (pick_lsb(aq.size(), lq.size(), m_ptr)) begin
          m_res <= lq[0].res; m_id <= lq[0].id; m_jump <= 1'b0; m_pc <= 32'h0; m_src <= 1'b1;
          void'(lq.pop_front());
        end else if (aq.size() != 0) begin
          m_res <= aq[0].res; m_id <= aq[0].id; m_jump <= aq[0].jump; m_pc <= aq[0].pc;
          m_src <= 1'b0;
          void'(aq.pop_front());
        end
      end
    end
  end

  // ---------------- compare process + LSB monitor ----------------
  logic     log_en   = 1'b0;
  logic     saw_full = 1'b0;
  logic [4:0] lsb_log[$];

  always @(negedge clk) begin
    check("cdb_valid", cdb_valid, m_valid);
    check("cdb_res", cdb_res, m_res);
    check("cdb_rob_id", cdb_rob_id, m_id);
    check("cdb_jump", cdb_jump, m_jump);
    check("cdb_pc", cdb_pc, m_pc);
    check("cdb_src", cdb_src, m_src);
    check("alu_ready", alu_ready, aq.size() < DEPTH);
    check("lsb_ready", lsb_ready, lq.size() < DEPTH);
    if (log_en && cdb_valid && cdb_src) lsb_log.push_back(cdb_rob_id);
    if (log_en && !lsb_ready) saw_full = 1'b1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present results only when the model says the FIFO has room.
  task automatic drive(input logic want_a, input logic [4:0] a_id,
                       input logic want_l, input logic [4:0] l_id,
                       output logic acc_a, output logic acc_l);
    acc_a = want_a && (aq.size() < DEPTH);
    acc_l = want_l && (lq.size() < DEPTH);
    alu_valid   = acc_a;
    alu_res     = 32'h1000 + 32'(a_id);
    alu_rob_id  = a_id;
    alu_jump    = a_id[0];
    alu_jump_pc = 32'h2000 + 32'(a_id);
    lsb_valid   = acc_l;
    lsb_res     = 32'h3000 + 32'(l_id);
    lsb_rob_id  = l_id;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    lsb_valid = 1'b0;
  endtask

`ifdef CDB_LSB_PRIORITY_EN
  localparam logic FIRST_SRC = 1'b1;
`else
  localparam logic FIRST_SRC = 1'b0;
`endif

  initial begin
    logic acc_a, acc_l;
    int   ai, li;

    // Reset state.
    #1;
    check("rst cdb_valid", cdb_valid, 1'b0);
    check("rst alu_ready", alu_ready, 1'b1);
    check("rst lsb_ready", lsb_ready, 1'b1);
    repeat (2) cyc();
    #3 rst = 1'b0;
    cyc();

    // 1: ALU only, one-cycle latency, single pulse.
    alu_valid = 1'b1; alu_res = 32'h11; alu_rob_id = 5'd3; alu_jump = 1'b1; alu_jump_pc = 32'h40;
    cyc();
    idle();
    check("t1 valid", cdb_valid, 1'b1);
    check("t1 res", cdb_res, 32'h11);
    check("t1 id", cdb_rob_id, 5'd3);
    check("t1 src", cdb_src, 1'b0);
    check("t1 pc", cdb_pc, 32'h40);
    cyc();
    check("t1 gap", cdb_valid, 1'b0);

    // 2: collision, pointer starts at ALU.
    alu_valid = 1'b1; alu_res = 32'hA; alu_rob_id = 5'd1; alu_jump = 1'b0; alu_jump_pc = 32'h0;
    lsb_valid = 1'b1; lsb_res = 32'hB; lsb_rob_id = 5'd2;
    cyc();
    idle();
    check("t2 first valid", cdb_valid, 1'b1);
    check("t2 first src", cdb_src, FIRST_SRC);
    check("t2 first res", cdb_res, FIRST_SRC ? 32'hB : 32'hA);
    cyc();
    check("t2 second valid", cdb_valid, 1'b1);
    check("t2 second src", cdb_src, !FIRST_SRC);
    check("t2 second id", cdb_rob_id, FIRST_SRC ? 5'd1 : 5'd2);
    check("t2 second jump", cdb_jump, 1'b0);
    cyc();
    check("t2 idle", cdb_valid, 1'b0);
    check("t2 hold res", cdb_res, FIRST_SRC ? 32'hA : 32'hB);

    // 3: back-pressure, LSB ids 0..7 and ALU ids 20..27 streaming together.
    ai = 0; li = 0;
    log_en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      drive(ai < 8, 5'(20 + ai), li < 8, 5'(li), acc_a, acc_l);
      cyc();
      if (acc_a) ai++;
      if (acc_l) li++;
    end
    idle();
    repeat (4) cyc();
    log_en = 1'b0;
    check("t3 lsb issued", 32'(li), 32'd8);
    check("t3 alu issued", 32'(ai), 32'd8);
    check("t3 lsb_ready dropped", saw_full, 1'b1);
    check("t3 lsb count", 32'(lsb_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < lsb_log.size(); i++)
      check($sformatf("t3 lsb order %0d", i), lsb_log[i], 5'(i));

    // 4: flush with both FIFOs partly filled.
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 5'(10 + c), 1'b1, 5'(14 + c), acc_a, acc_l);
      cyc();
    end
    wrong_commit = 1'b1;
    drive(1'b1, 5'd30, 1'b1, 5'd31, acc_a, acc_l);
    cyc();
    wrong_commit = 1'b0;
    idle();
    check("t4 valid after flush", cdb_valid, 1'b0);
    check("t4 alu_ready", alu_ready, 1'b1);
    check("t4 lsb_ready", lsb_ready, 1'b1);
    for (int c = 0; c < 4; c++) begin
      cyc();
      check("t4 no flushed result", cdb_valid, 1'b0);
    end

    // 5: stall mid-stream; inputs wiggle and must be ignored.
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 5'(c), 1'b1, 5'(8 + c), acc_a, acc_l);
      cyc();
    end
    rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      alu_valid = 1'($urandom_range(0, 1)); alu_res = $urandom; alu_rob_id = 5'(c + 16);
      lsb_valid = 1'($urandom_range(0, 1)); lsb_res = $urandom; lsb_rob_id = 5'(c + 24);
      cyc();
      check("t5 frozen valid", cdb_valid, 1'b1);
    end
    rdy = 1'b1;
    idle();
    repeat (8) cyc();
    check("t5 drained", cdb_valid, 1'b0);

    // 6: asynchronous reset between edges.
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 5'(4 + c), 1'b1, 5'(6 + c), acc_a, acc_l);
      cyc();
    end
    idle();
    #2 rst = 1'b1;
    #1;
    check("t6 rst valid", cdb_valid, 1'b0);
    check("t6 rst res", cdb_res, 32'h0);
    check("t6 rst id", cdb_rob_id, 5'd0);
    check("t6 rst pc", cdb_pc, 32'h0);
    check("t6 rst alu_ready", alu_ready, 1'b1);
    #2 rst = 1'b0;
    cyc();
    alu_valid = 1'b1; alu_res = 32'h77; alu_rob_id = 5'd9; alu_jump = 1'b0; alu_jump_pc = 32'h0;
    cyc();
    idle();
    check("t6 post-rst valid", cdb_valid, 1'b1);
    check("t6 post-rst res", cdb_res, 32'h77);
    check("t6 post-rst id", cdb_rob_id, 5'd9);
    cyc();
    check("t6 post-rst gap", cdb_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
